// File: rtl/onehot_pkg.sv
// Shared definitions for the one-hot ring counter and its monitor.
package onehot_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ZERO  = 2'b01;
  localparam logic [1:0] ERR_MULTI = 2'b10;
  localparam logic [1:0] ERR_SEQ   = 2'b11;

endpackage

// File: rtl/onehot_enc.sv
// Combinational one-hot to binary encoder with zero and multi-hot detection.
module onehot_enc #(
  parameter int WIDTH = 8,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] oh_in,
  output logic [IDXW-1:0]  idx,
  output logic             is_zero,
  output logic             is_multi
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (oh_in[i]) idx = IDXW'(i);
    end
  end

  assign is_zero  = (oh_in == '0);
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign is_multi = |(oh_in & (oh_in - ONE));

endmodule

// File: rtl/onehot_monitor.sv
// Tracks the one-hot ring counter: binary index, revolutions, and step legality.
//
// state | meaning
// IDLE  | after reset, waiting for the first clean one-hot sample
// RUN   | locked; every sample checked against the expected step
// FAULT | error seen; waiting for a clean one-hot sample to relock
module onehot_monitor
  import onehot_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDXW  = $clog2(WIDTH),
  parameter int REVW  = 8,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] oh_in,
  input  logic             clr_err,
  output logic [IDXW-1:0]  idx,
  output logic             valid,
  output logic             wrap,
  output logic [REVW-1:0]  rev_cnt,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [ERRW-1:0]  err_cnt
);

  state_t           state;
  logic             en_q;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] expected;
  logic [IDXW-1:0]  enc_idx;
  logic             is_zero;
  logic             is_multi;
  logic             is_onehot;
  logic             step_wrap;
  logic [1:0]       bad_code;
  logic [ERRW-1:0]  cnt_next;

  onehot_enc #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_enc (
    .oh_in    (oh_in),
    .idx      (enc_idx),
    .is_zero  (is_zero),
    .is_multi (is_multi)
  );

  assign expected  = en_q ? {prev[WIDTH-2:0], prev[WIDTH-1]} : prev;
  assign is_onehot = !is_zero && !is_multi;
  assign step_wrap = en_q && prev[WIDTH-1] && oh_in[0];

  always_comb begin
    bad_code = ERR_NONE;
    if (is_zero)                bad_code = ERR_ZERO;
    else if (is_multi)          bad_code = ERR_MULTI;
    else if (oh_in != expected) bad_code = ERR_SEQ;
  end

  // A clear coinciding with a new error restarts the count at one.
  assign cnt_next = clr_err   ? ERRW'(1) :
                    &err_cnt  ? err_cnt  : err_cnt + ERRW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      en_q     <= 1'b0;
      prev     <= '0;
      idx      <= '0;
      valid    <= 1'b0;
      wrap     <= 1'b0;
      rev_cnt  <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      err_cnt  <= '0;
    end else begin
      en_q <= en;
      wrap <= 1'b0;
      if (clr_err) begin
        err      <= 1'b0;
        err_code <= ERR_NONE;
        err_cnt  <= '0;
      end
      case (state)
        IDLE, FAULT: begin
          if (is_onehot) begin
            prev  <= oh_in;
            idx   <= enc_idx;
            valid <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (bad_code != ERR_NONE) begin
            err      <= 1'b1;
            err_code <= bad_code;
            err_cnt  <= cnt_next;
            valid    <= 1'b0;
            state    <= FAULT;
          end else begin
            prev <= oh_in;
            idx  <= enc_idx;
            if (step_wrap) begin
              wrap    <= 1'b1;
              rev_cnt <= rev_cnt + REVW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_monitor.sv
// Self-checking bench for onehot_monitor: reference model feeds a scoreboard queue.
module tb_onehot_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] oh_in;
  logic       clr_err;
  logic [2:0] idx;
  logic       valid;
  logic       wrap;
  logic [7:0] rev_cnt;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  onehot_monitor dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .oh_in    (oh_in),
    .clr_err  (clr_err),
    .idx      (idx),
    .valid    (valid),
    .wrap     (wrap),
    .rev_cnt  (rev_cnt),
    .err      (err),
    .err_code (err_code),
    .err_cnt  (err_cnt)
  );

  typedef struct packed {
    logic [2:0] idx;
    logic       valid;
    logic       wrap;
    logic [7:0] rev;
    logic       err;
    logic [1:0] code;
    logic [7:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  obs_t got, want;
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model state (0 idle, 1 run, 2 fault)
  int         m_state;
  logic [7:0] m_prev;
  logic       m_enq;
  logic [2:0] m_idx;
  logic       m_valid, m_wrap, m_err;
  logic [7:0] m_rev, m_cnt;
  logic [1:0] m_code;

  function automatic obs_t observe();
    obs_t o;
    o.idx = idx; o.valid = valid; o.wrap = wrap; o.rev = rev_cnt;
    o.err = err; o.code = err_code; o.cnt = err_cnt;
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.idx = m_idx; o.valid = m_valid; o.wrap = m_wrap; o.rev = m_rev;
    o.err = m_err; o.code = m_code; o.cnt = m_cnt;
    return o;
  endfunction

  task automatic model_reset();
    m_state = 0; m_prev = 8'h00; m_enq = 1'b0; m_idx = 3'd0;
    m_valid = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
    m_rev = 8'd0; m_cnt = 8'd0; m_code = 2'b00;
  endtask

  task automatic model_step(input logic e, input logic [7:0] oh, input logic c);
    logic [7:0] nxt;
    logic [1:0] code;
    if (c) begin m_err = 1'b0; m_code = 2'b00; m_cnt = 8'd0; end
    m_wrap = 1'b0;
    nxt  = m_enq ? ((m_prev << 1) | (m_prev >> 7)) : m_prev;
    code = 2'b00;
    if (m_state == 1) begin
      if (oh == 8'h00)               code = 2'b01;
      else if ($countones(oh) > 1)   code = 2'b10;
      else if (oh != nxt)            code = 2'b11;
    end
    if (code != 2'b00) begin
      m_err = 1'b1; m_code = code;
      m_cnt = c ? 8'd1 : (m_cnt == 8'hFF ? 8'hFF : m_cnt + 8'd1);
      m_valid = 1'b0; m_state = 2;
    end else if ($countones(oh) == 1) begin
      if (m_state == 1 && m_enq && m_prev == 8'h80 && oh == 8'h01) begin
        m_wrap = 1'b1; m_rev = m_rev + 8'd1;
      end
      m_prev = oh;
      for (int i = 0; i < 8; i++) if (oh[i]) m_idx = i[2:0];
      m_valid = 1'b1; m_state = 1;
    end
    m_enq = e;
  endtask

  task automatic drive_now(input logic e, input logic [7:0] oh, input logic c);
    en = e; oh_in = oh; clr_err = c;
    model_step(e, oh, c);
    exp_q.push_back(model_obs());
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic e, input logic [7:0] oh, input logic c);
    @(negedge clk);
    drive_now(e, oh, c);
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; oh_in = 8'h00; clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (observe() !== '0) begin
      n_fail++; $display("FAIL reset_values: got %h want 000000", observe());
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_revolution();
    int wraps = 0;
    for (int k = 0; k <= 8; k++) begin
      cycle(1'b1, 8'h01 << (k % 8), 1'b0);
      got = observe(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL rev_step%0d: got %h want %h", k, got, want);
      end
      n_checks++;
      if (idx !== 3'(k % 8) || valid !== 1'b1) begin
        n_fail++; $display("FAIL rev_idx%0d: got idx=%0d valid=%b want idx=%0d valid=1", k, idx, valid, k % 8);
      end
      if (wrap === 1'b1) wraps++;
    end
    n_checks++;
    if (wraps != 1 || rev_cnt !== 8'd1 || err !== 1'b0) begin
      n_fail++; $display("FAIL rev_total: got wraps=%0d rev=%0d err=%b want 1 1 0", wraps, rev_cnt, err);
    end
  endtask

  task automatic test_hold();
    logic [7:0] seq [4] = '{8'h02, 8'h04, 8'h08, 8'h10};
    for (int k = 0; k < 8; k++) begin
      cycle(k < 3, (k < 4) ? seq[k] : 8'h10, 1'b0);
      got = observe(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL hold_step%0d: got %h want %h", k, got, want);
      end
      if (k >= 4) begin
        n_checks++;
        if (idx !== 3'd4 || err !== 1'b0 || wrap !== 1'b0) begin
          n_fail++; $display("FAIL hold_steady%0d: got idx=%0d err=%b wrap=%b want 4 0 0", k, idx, err, wrap);
        end
      end
    end
  endtask

  task automatic test_zero();
    cycle(1'b0, 8'h00, 1'b0);
    got = observe(); want = exp_q.pop_front();
    n_checks++;
    if (got !== want || err_code !== 2'b01 || err_cnt !== 8'd1 || valid !== 1'b0) begin
      n_fail++; $display("FAIL zero_err: got %h want %h (code 01 cnt 1 valid 0)", got, want);
    end
    cycle(1'b0, 8'h04, 1'b0);
    got = observe(); want = exp_q.pop_front();
    n_checks++;
    if (got !== want || valid !== 1'b1 || idx !== 3'd2) begin
      n_fail++; $display("FAIL zero_relock: got %h want %h (valid 1 idx 2)", got, want);
    end
  endtask

  task automatic test_multi_seq();
    logic [7:0] ohs  [4] = '{8'h04, 8'h18, 8'h02, 8'h08};
    logic       clrs [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] codes[4] = '{2'b00, 2'b10, 2'b10, 2'b11};
    logic [7:0] cnts [4] = '{8'd0, 8'd1, 8'd1, 8'd2};
    for (int k = 0; k < 4; k++) begin
      cycle(k != 0, ohs[k], clrs[k]);
      got = observe(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want || err_code !== codes[k] || err_cnt !== cnts[k]) begin
        n_fail++; $display("FAIL multi_seq%0d: got %h want %h (code %b cnt %0d)", k, got, want, codes[k], cnts[k]);
      end
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 256; k++) begin
      cycle(1'b0, 8'h01, 1'b0);
      cycle(1'b0, 8'h00, 1'b0);
      for (int j = 0; j < 2; j++) begin
        got = observe(); want = exp_q.pop_front();
        if (j == 1) begin
          n_checks++;
          if (got !== want) begin
            n_fail++; $display("FAIL sat_pair%0d: got %h want %h", k, got, want);
          end
        end
      end
    end
    n_checks++;
    if (err_cnt !== 8'hFF) begin
      n_fail++; $display("FAIL sat_cnt: got %0d want 255", err_cnt);
    end
    cycle(1'b0, 8'h00, 1'b1);
    got = observe(); want = exp_q.pop_front();
    n_checks++;
    if (got !== want || err !== 1'b0 || err_code !== 2'b00 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL clr_alone: got %h want %h (err outputs 0)", got, want);
    end
    cycle(1'b0, 8'h01, 1'b0);
    got = observe(); want = exp_q.pop_front();
    cycle(1'b0, 8'h00, 1'b1);
    got = observe(); want = exp_q.pop_front();
    n_checks++;
    if (got !== want || err !== 1'b1 || err_code !== 2'b01 || err_cnt !== 8'd1) begin
      n_fail++; $display("FAIL clr_vs_err: got %h want %h (err 1 code 01 cnt 1)", got, want);
    end
  endtask

  task automatic test_async_reset();
    int pos = 0;
    cycle(1'b1, 8'h01, 1'b0);
    got = observe(); want = exp_q.pop_front();
    for (int k = 1; k <= 21; k++) begin
      pos = (pos + 1) % 8;
      cycle(1'b1, 8'h01 << pos, 1'b0);
      got = observe(); want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL spin_step%0d: got %h want %h", k, got, want);
      end
    end
    n_checks++;
    if (idx !== 3'd5 || rev_cnt !== 8'd3) begin
      n_fail++; $display("FAIL pre_reset: got idx=%0d rev=%0d want 5 3", idx, rev_cnt);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (observe() !== '0) begin
      n_fail++; $display("FAIL async_reset: got %h want 000000", observe());
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (observe() !== '0) begin
      n_fail++; $display("FAIL reset_hold: got %h want 000000", observe());
    end
    @(negedge clk);
    rst = 1'b1;
    drive_now(1'b0, 8'h20, 1'b0);
    got = observe(); want = exp_q.pop_front();
    n_checks++;
    if (got !== want || valid !== 1'b1 || idx !== 3'd5 || err !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_relock: got %h want %h (valid 1 idx 5 err 0)", got, want);
    end
  endtask

  initial begin
    test_reset();
    test_revolution();
    test_hold();
    test_zero();
    test_multi_seq();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_monitor.md
# onehot_monitor

Downstream consumer of the 8-bit one-hot ring counter: samples the counter's one-hot output every clock, encodes it to a binary index, and tracks completed revolutions. It also checks that every transition is legal for the enable that drove the counter, raising a sticky error with a code and a saturating error count. It sits between the counter and the phase-sequencing logic, which uses `idx` and `wrap` and trusts them only while `valid` is high.

## Interface

- `WIDTH`, 8, one-hot vector width (≥2).
- `IDXW`, `$clog2(WIDTH)`, index width (3 at default).
- `REVW`, 8, revolution counter width.
- `ERRW`, 8, error counter width.

- `clk`  in  1  rising-edge clock, shared with the counter.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `en`  in  1  same enable that drives the counter.
- `oh_in`  in  WIDTH  counter one-hot output.
- `clr_err`  in  1  synchronous clear of `err`, `err_code`, `err_cnt`.
- `idx`  out  IDXW  binary position of the last accepted one-hot sample.
- `valid`  out  1  monitor locked; `idx` and `wrap` trustworthy.
- `wrap`  out  1  one-cycle pulse on an accepted MSB→bit0 step.
- `rev_cnt`  out  REVW  completed revolutions, modulo 2^REVW.
- `err`  out  1  sticky error flag.
- `err_code`  out  2  00 none, 01 ZERO (no bit set), 10 MULTI (>1 bit), 11 SEQ (illegal step).
- `err_cnt`  out  ERRW  errors detected, saturating at all-ones.

## Operation

- Legal step: bit i → bit i+1, bit WIDTH-1 → bit 0 (rotate left).
- `en_q`: `en` registered once. Expected sample = `en_q` ? rotl(prev) : prev, where `prev` is the last accepted sample.
- FSM states:
  - IDLE: reset state. The first sample that is exactly one-hot is accepted, with no SEQ check. Go to RUN and set `valid`. Non-one-hot samples in IDLE are ignored and flag no error, covering counter start-up.
  - RUN: classify each sample.
    - Zero → ZERO.
    - Popcount >1 → MULTI.
    - One-hot ≠ expected → SEQ.
    - Otherwise accept: update `idx` and `prev`; if the step was WIDTH-1→0 and `en_q` is high, pulse `wrap` and increment `rev_cnt`.
  - On any error: `err`←1, `err_code`←code, `err_cnt` increments (saturating). `valid`←0 and the FSM goes to FAULT; `idx` holds its last value.
  - FAULT: the next exactly one-hot sample is accepted without a SEQ check and the FSM returns to RUN. `rev_cnt` is preserved, and no `wrap` pulse is generated on this relock. Further bad samples in FAULT do not count.
- `err_code` holds the most recent error.
- `clr_err` alone clears `err`, `err_code` and `err_cnt`; it does not change FSM state.
- `clr_err` in the same cycle as a new error: the error wins, giving `err`=1, `err_code`=new code, `err_cnt`=1.
- `rev_cnt` wraps from all-ones to 0 silently.

## Timing

- All outputs registered; one-cycle latency from `oh_in` sampled at edge n to outputs valid after edge n.
- `wrap` is high for exactly the one cycle following the accepting edge.
- Reset values: `idx`=0, `valid`=0, `wrap`=0, `rev_cnt`=0, `err`=0, `err_code`=00, `err_cnt`=0, `en_q`=0, state IDLE.
- Reset asserted mid-operation clears everything immediately, with no clock needed.
- After reset deassertion, the first accept can occur on the next edge.

## Structure

- Shared package `onehot_pkg`: state enum (IDLE, RUN, FAULT), error code constants (`ERR_NONE`, `ERR_ZERO`, `ERR_MULTI`, `ERR_SEQ`), and a default `WIDTH` constant shared with the counter.
- One sub-module: `onehot_enc`, combinational, `oh_in` → {`idx`, `is_zero`, `is_multi`}; it is also reusable elsewhere.
- Top level holds the FSM, `en_q`, `prev`, and the counters.

## Test plan

- Reset, then `oh_in`=00000001 with `en` held 1 for 8 cycles: `valid`=1 from cycle 1; `idx` goes 0,1,…,7,0; one `wrap` pulse; `rev_cnt`=1; `err`=0.
- `en`=0 with `oh_in` constant 00010000 for 5 cycles: `idx`=4 steady, no error, no `wrap`.
- In RUN, inject 00000000: `err`=1, `err_code`=01, `err_cnt`=1, `valid`=0. The next sample 00000100 relocks: `valid`=1, `idx`=2.
- In RUN, inject 00011000, then from a relocked 00000010 with `en_q`=1 jump to 00001000: `err_code`=10 then 11, `err_cnt`=2.
- Force errors until 255: `err_cnt` stays at 255. Pulse `clr_err` alone: all error outputs become 0. Pulse `clr_err` in a ZERO-error cycle: `err_cnt`=1, `err_code`=01.
- Drive `rst`=0 asynchronously mid-revolution (`idx`=5, `rev_cnt`=3): all outputs reset before the next edge; the first one-hot sample after release relocks with no error.
